// File: rtl/host_rx_if.sv
// Host-side drain of the CDC FIFO: 1-cycle-latency read port in, valid/ready out, sop/eop framing check.
// Optional statistics counters are built when HOST_STATS_EN is defined.
module host_rx_if #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 3,
    parameter int BUF_W  = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                               clk_host,
    input  logic                               rst_n,
    input  logic                               valid_fifo,
    input  logic [BUF_W+LEN_W+2+DATA_W-1:0]    fifo_data,
    output logic                               rd_en,
    input  logic                               host_ready,
    output logic                               valid_out,
    output logic [DATA_W-1:0]                  data_out,
    output logic [LEN_W-1:0]                   length_out,
    output logic [BUF_W-1:0]                   buffer_out,
    output logic                               sop_out,
    output logic                               eop_out,
    output logic                               frame_err,
`ifdef HOST_STATS_EN
    output logic [CNT_W-1:0]                   pkt_count,
    output logic [CNT_W-1:0]                   word_count,
    output logic [CNT_W-1:0]                   err_count,
`endif
    output logic                               o_dbg_state
);
    // Handshake: a word transfers on every rising edge where valid_out && host_ready.
    localparam int WORD_W = BUF_W + LEN_W + 2 + DATA_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int CALC_W = OCC_W + 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [OCC_W-1:0]  r_occ;
    logic              r_inflight;
    logic              r_frame_err;
    state_t            r_state;

    logic              w_pop;
    logic              w_cap_sop;
    logic              w_cap_eop;
    logic              w_orphan;
    logic              w_push;
    logic              w_err;
    logic [CALC_W-1:0] w_level;
    logic [WORD_W-1:0] w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid_out = (r_occ != '0);
    assign w_pop     = valid_out && host_ready;
    // Count the word already requested so the buffer can never be over-subscribed.
    assign w_level   = CALC_W'(r_occ) + CALC_W'(r_inflight) - CALC_W'(w_pop);
    assign rd_en     = rst_n && valid_fifo && (w_level < CALC_W'(DEPTH));

    assign w_cap_sop = fifo_data[DATA_W+1];
    assign w_cap_eop = fifo_data[DATA_W];
    assign w_orphan  = (r_state == ST_IDLE) && !w_cap_sop;
    assign w_push    = r_inflight && !w_orphan;
    assign w_err     = r_inflight && (w_orphan || ((r_state == ST_IN_PKT) && w_cap_sop));

    assign w_head      = r_mem[r_head];
    assign buffer_out  = w_head[WORD_W-1 -: BUF_W];
    assign length_out  = w_head[DATA_W+2 +: LEN_W];
    assign sop_out     = w_head[DATA_W+1];
    assign eop_out     = w_head[DATA_W];
    assign data_out    = w_head[DATA_W-1:0];
    assign frame_err   = r_frame_err;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk_host) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_occ       <= '0;
            r_inflight  <= 1'b0;
            r_frame_err <= 1'b0;
            r_state     <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_inflight  <= rd_en;
            r_frame_err <= w_err;
            if (w_push) begin
                r_mem[r_tail] <= fifo_data;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) r_head <= ptr_inc(r_head);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            // A stray sop inside a packet restarts the packet rather than dropping data.
            if (r_inflight) begin
                case (r_state)
                    ST_IDLE:   if (w_cap_sop && !w_cap_eop) r_state <= ST_IN_PKT;
                    ST_IN_PKT: if (w_cap_eop) r_state <= ST_IDLE;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef HOST_STATS_EN
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk_host) begin
        if (!rst_n) begin
            r_pkt_cnt  <= '0;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
            if (w_pop && eop_out) r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if (w_err) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign pkt_count  = r_pkt_cnt;
    assign word_count = r_word_cnt;
    assign err_count  = r_err_cnt;
`endif

endmodule

// File: tb/tb_host_rx_if.sv
// Randomised scoreboard bench for host_rx_if: FIFO model, packet-level reference model, decoupled monitor.
module tb_host_rx_if;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 3;
    localparam int BUF_W  = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 32;
    localparam int WORD_W = BUF_W + LEN_W + 2 + DATA_W;

    logic              clk_host = 1'b0;
    logic              rst_n;
    logic              valid_fifo;
    logic [WORD_W-1:0] fifo_data;
    logic              rd_en;
    logic              host_ready;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic [LEN_W-1:0]  length_out;
    logic [BUF_W-1:0]  buffer_out;
    logic              sop_out;
    logic              eop_out;
    logic              frame_err;
    logic              o_dbg_state;
`ifdef HOST_STATS_EN
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  word_count;
    logic [CNT_W-1:0]  err_count;
`endif

    host_rx_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_W(BUF_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_host(clk_host), .rst_n(rst_n), .valid_fifo(valid_fifo), .fifo_data(fifo_data),
        .rd_en(rd_en), .host_ready(host_ready), .valid_out(valid_out), .data_out(data_out),
        .length_out(length_out), .buffer_out(buffer_out), .sop_out(sop_out), .eop_out(eop_out),
        .frame_err(frame_err),
`ifdef HOST_STATS_EN
        .pkt_count(pkt_count), .word_count(word_count), .err_count(err_count),
`endif
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_host = ~clk_host;
    int cyc = 0;
    always @(posedge clk_host) cyc <= cyc + 1;

    // ---------------- shared state ----------------
    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] fifo_q[$];
    logic [WORD_W-1:0] exp_q[$];
    int  ready_mode = 1;        // 0: hold low, 1: hold high, 2: random
    bit  gap_en = 0;
    bit  in_pkt = 0;
    int  exp_err = 0, exp_pkts = 0, exp_words = 0;
    int  err_seen = 0;
    int  rd_total = 0, rrun = 0, rmax = 0, vrun = 0, vmax = 0;
    int  first_rd = -1, first_v = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: framing rules applied to each word in FIFO order.
    task automatic push_word(input bit sop, input bit eop, input logic [LEN_W-1:0] len,
                             input logic [BUF_W-1:0] bid, input logic [DATA_W-1:0] data);
        logic [WORD_W-1:0] w;
        w = {bid, len, sop, eop, data};
        fifo_q.push_back(w);
        if (!in_pkt && !sop) begin
            exp_err++;
        end else begin
            if (in_pkt && sop) exp_err++;
            exp_q.push_back(w);
            exp_words++;
            if (eop) exp_pkts++;
            in_pkt = !eop;
        end
    endtask

    task automatic push_rand(input bit sop, input bit eop);
        push_word(sop, eop, LEN_W'($urandom_range(0, 7)), BUF_W'($urandom_range(0, 255)),
                  {$urandom, $urandom});
    endtask

    // ---------------- FIFO model with 1-cycle read latency ----------------
    initial begin
        logic [WORD_W-1:0] pend;
        logic [95:0]       r96;
        bit                have_pend;
        have_pend  = 0;
        pend       = '0;
        valid_fifo = 1'b0;
        host_ready = 1'b0;
        fifo_data  = '0;
        forever begin
            @(negedge clk_host);
            r96 = {$urandom, $urandom, $urandom};
            fifo_data  = have_pend ? pend : r96[WORD_W-1:0];
            host_ready = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
            valid_fifo = (fifo_q.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
            #1;
            if (rd_en) begin
                if (fifo_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_en_on_empty: got rd_en=1 expected 0");
                    have_pend = 0;
                end else begin
                    pend = fifo_q.pop_front();
                    have_pend = 1;
                end
                rd_total++;
                rrun++;
                if (rrun > rmax) rmax = rrun;
                if (first_rd < 0) first_rd = cyc;
            end else begin
                have_pend = 0;
                rrun = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [WORD_W-1:0] cur, prev, exp;
        bit hold_prev;
        hold_prev = 0;
        prev = '0;
        forever begin
            @(negedge clk_host);
            #2;
            if (!rst_n) begin
                hold_prev = 0;
                vrun = 0;
            end else begin
                if (frame_err) err_seen++;
                cur = {buffer_out, length_out, sop_out, eop_out, data_out};
                if (hold_prev) begin
                    check("hold_valid", valid_out, 1'b1);
                    check("hold_word", cur, prev);
                end
                if (valid_out) begin
                    if (first_v < 0) first_v = cyc;
                    vrun++;
                    if (vrun > vmax) vmax = vrun;
                    if (host_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_word: got %0h expected none", cur);
                        end else begin
                            exp = exp_q.pop_front();
                            check("word", cur, exp);
                        end
                    end
                    hold_prev = !host_ready;
                    prev = cur;
                end else begin
                    hold_prev = 0;
                    vrun = 0;
                end
            end
        end
    end

    // ---------------- phase helpers ----------------
    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 500) begin
            @(posedge clk_host);
            n++;
        end
        repeat (4) @(posedge clk_host);
        #1;
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        check("frame_err_total", err_seen, exp_err);
`ifdef HOST_STATS_EN
        check("pkt_count", pkt_count, exp_pkts);
        check("word_count", word_count, exp_words);
        check("err_count", err_count, exp_err);
`endif
    endtask

    task automatic check_reset_state();
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_out", data_out, '0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_state", o_dbg_state, 1'b0);
`ifdef HOST_STATS_EN
        check("rst_pkt_count", pkt_count, 0);
        check("rst_word_count", word_count, 0);
        check("rst_err_count", err_count, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_host);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        // 3-word packet, latency and back-to-back delivery
        first_rd = -1; first_v = -1; vmax = 0;
        base = err_seen;
        push_word(1, 0, 3'd0, 8'h11, 64'hA0);
        push_word(0, 0, 3'd0, 8'h11, 64'hA1);
        push_word(0, 1, 3'd5, 8'h11, 64'hA2);
        drain();
        check("latency", first_v - first_rd, 2);
        check("t1_valid_run", vmax, 3);
        check("t1_no_err", err_seen - base, 0);

        // 10 single-word packets at full rate
        rmax = 0; vmax = 0;
        for (int i = 0; i < 10; i++) push_rand(1, 1);
        drain();
        check("t2_rd_run", rmax, 10);
        check("t2_valid_run", vmax, 10);

        // back-pressure: only DEPTH words leave the FIFO
        ready_mode = 0;
        base = rd_total;
        push_rand(1, 0);
        for (int i = 0; i < 3; i++) push_rand(0, 0);
        push_rand(0, 1);
        repeat (12) @(posedge clk_host);
        #1;
        check("t3_captured", rd_total - base, DEPTH);
        check("t3_rd_en_low", rd_en, 1'b0);
        check("t3_valid_held", valid_out, 1'b1);
        ready_mode = 1;
        drain();

        // orphan in IDLE, then a good packet
        base = err_seen;
        push_rand(0, 0);
        push_rand(1, 0);
        push_rand(0, 1);
        drain();
        check("t4_orphan_err", err_seen - base, 1);

        // missing eop: sop, body, sop
        base = err_seen;
        push_rand(1, 0);
        push_rand(0, 0);
        push_rand(1, 0);
        drain();
        check("t5_err", err_seen - base, 1);
        check("t5_state_in_pkt", o_dbg_state, 1'b1);
        push_rand(0, 1);
        drain();
        check("t5_state_idle", o_dbg_state, 1'b0);

        // randomised traffic with gaps and random back-pressure
        ready_mode = 2;
        gap_en = 1;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 15; i++)
                push_rand($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            repeat ($urandom_range(5, 30)) @(posedge clk_host);
            #1;
        end
        drain();
        ready_mode = 1;
        gap_en = 0;
        if (in_pkt) begin
            push_rand(0, 1);
            drain();
        end

        // reset mid-stream with words buffered and one in flight
        push_rand(1, 0);
        for (int i = 0; i < 4; i++) push_rand(0, 0);
        push_rand(0, 1);
        repeat (4) @(posedge clk_host);
        #1;
        rst_n = 1'b0;
        ready_mode = 0;
        @(posedge clk_host);
        #1;
        exp_q.delete();
        fifo_q.delete();
        in_pkt = 0;
        exp_err = 0; exp_pkts = 0; exp_words = 0; err_seen = 0;
        check_reset_state();
        rst_n = 1'b1;
        ready_mode = 1;
        push_rand(1, 0);
        push_rand(0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
